dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
Data-side memory controller and responder for the store/load buffer's mc_ld_*/mc_st_* request interface. It accepts one load or store at a time and performs it as byte-serial accesses on the 8-bit RAM port. For loads it assembles the bytes and sign- or zero-extends the result; for both it answers with a one-cycle done pulse. Sits between the SLB and the RAM/IO bus.

Parameters:
ADDR_W, 32, address width (`ADDR_TP)
IO_BASE_HI, 2'b11, addr[17:16] value that marks the IO range (0x30000+)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low = freeze
rb  in  1  rollback flush
ld_ena  in  1  load request (level, held until done)
ld_addr  in  32  load byte address
ld_len  in  4  bytes-1: 0 byte, 1 half, 3 word
ld_sext  in  1  sign-extend result
ld_src  in  `ROB_IDX_TP  ROB tag of the load
ld_done  out  1  one-cycle load-complete pulse
ld_data  out  32  extended load result, valid with ld_done
ld_dest  out  `ROB_IDX_TP  tag echoed with ld_done
st_ena  in  1  store request (level)
st_addr  in  32  store byte address
st_len  in  4  bytes-1
st_data  in  32  store data, LSB first
st_done  out  1  one-cycle store-complete pulse
io_buffer_full  in  1  IO write buffer full
mem_din  in  8  RAM read data, valid 1 cycle after mem_a
mem_dout  out  8  RAM write data
mem_a  out  32  RAM byte address
mem_wr  out  1  write strobe; 1 = write

Behaviour:
- Reset (rst high at posedge, sync): state=IDLE; mem_a, mem_dout, mem_wr, ld_done, st_done, ld_data, ld_dest, cnt all 0. rst has priority over rb and rdy.
- rdy low: all registers hold. mem_wr is driven as wr_reg & rdy, so no write is issued during a stall.
- States: IDLE, LOAD, STORE, COOL.
- IDLE, st_ena high: accept the store, except a store to the IO range (st_addr[17:16]==IO_BASE_HI) is not accepted while io_buffer_full is high. Stores have priority over loads.
- IDLE, ld_ena high, no store accepted: accept the load.
- Load accepted at edge T: mem_a<=ld_addr, cnt<=0, latch len/sext/src, state=LOAD.
- LOAD, each edge: capture mem_din into byte cnt of the buffer. If cnt<len: mem_a<=addr+cnt+1, cnt++.
- LOAD, edge that captures byte len (edge T+len+1): ld_done<=1, ld_data<=extended value, ld_dest<=src, mem_a<=0, state=COOL.
- Load extension: byte/half sign-extended from bit 7/15 when sext=1, zero-extended otherwise. Word is passed through unchanged.
- Load latency: done is high in the cycle after edge T+len+1 (byte: 2 edges after accept, word: 5).
- Store accepted at edge T: mem_a<=st_addr, mem_dout<=st_data[7:0], wr_reg<=1, cnt<=0, state=STORE.
- STORE, each edge while cnt<len: mem_a<=addr+cnt+1, mem_dout<=data byte cnt+1, cnt++.
- STORE, edge after the last byte is presented (T+len+1): wr_reg<=0, mem_a<=0, st_done<=1, state=COOL.
- COOL: lasts exactly one cycle; ld_ena/st_ena are ignored. This covers the requester dropping ena one edge after done. Next state IDLE.
- ld_done/st_done are one-cycle pulses, cleared on the following edge.
- Address arithmetic: addr+k is 32-bit and wraps at 2^32.
- len values other than 0/1/3 are treated as 3.
- rb while in LOAD: abort with no ld_done; mem_a<=0; state=COOL.
- rb while in IDLE: any pending load is ignored; state=COOL.
- rb while in STORE: no effect; the store completes and st_done pulses (already-committed stores are never dropped).
- rb in the same cycle as ld_done being registered: the done is suppressed.
- Only one outstanding request at a time.

Test Plan:
- rst mid-store (after byte 1 of a word store) -> next cycle mem_wr=0, state IDLE, no st_done, all outputs 0.
- LW addr 0x100, RAM bytes 0x100..0x103 = 78 56 34 12 -> mem_a sequence 100,101,102,103; ld_done one cycle with ld_data=0x12345678 and ld_dest=src; COOL ignores the still-high ld_ena.
- LB vs LBU at a byte holding 0x80 -> LB gives 0xFFFFFF80, LBU gives 0x00000080, each done 2 edges after accept. LH on 0xFF7F -> 0xFFFFFF7F.
- SH st_data=0xAABBCCDD addr 0x204 -> mem_wr=1 for 2 cycles with (0x204,DD),(0x205,CC); st_done pulses after; RAM holds DD CC.
- SB to 0x30000 with io_buffer_full=1 for 3 cycles -> no mem_wr and state stays IDLE; accepted on the first cycle it drops to 0; rdy low mid-store freezes mem_a and forces mem_wr=0.
- rb during LW cnt=2 -> no ld_done, COOL then IDLE. rb during SW -> all 4 bytes written and st_done still pulses.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-side memory controller: serves one SLB load or store at a time
// as byte-serial accesses on the 8-bit RAM port, with done pulses.
module dmem_ctrl #(
    parameter int          ADDR_W     = 32,
    parameter logic [1:0]  IO_BASE_HI = 2'b11,
    parameter int          ROB_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rb,
    input  logic              ld_ena,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [3:0]        ld_len,
    input  logic              ld_sext,
    input  logic [ROB_W-1:0]  ld_src,
    output logic              ld_done,
    output logic [31:0]       ld_data,
    output logic [ROB_W-1:0]  ld_dest,
    input  logic              st_ena,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [3:0]        st_len,
    input  logic [31:0]       st_data,
    output logic              st_done,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, COOL} state_t;

    state_t            state, n_state;
    logic              wr_reg, n_wr;
    logic [1:0]        cnt, n_cnt, len, n_len, nc;
    logic [ADDR_W-1:0] addr, n_addr, n_mem_a, step_a;
    logic              sext, n_sext;
    logic [ROB_W-1:0]  src, n_src, n_ld_dest;
    logic [31:0]       ld_buf, n_ld_buf, sdata, n_sdata, asm_w, ext_w, n_ld_data;
    logic [7:0]        n_mem_dout;
    logic              n_ld_done, n_st_done, st_ok;

    // Odd lengths (2, 4..15) collapse to a word access.
    function automatic logic [1:0] norm_len(input logic [3:0] l);
        case (l)
            4'd0:    return 2'd0;
            4'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    assign mem_wr = wr_reg & rdy;
    assign st_ok  = st_ena & ~((st_addr[17:16] == IO_BASE_HI) & io_buffer_full);
    assign nc     = cnt + 2'd1;
    assign step_a = addr + ADDR_W'(cnt) + ADDR_W'(1);

    always_comb begin
        asm_w = ld_buf;
        asm_w[{cnt, 3'b000} +: 8] = mem_din;
        ext_w = asm_w;
        case (len)
            2'd0: ext_w = sext ? {{24{asm_w[7]}}, asm_w[7:0]}
                               : {24'b0, asm_w[7:0]};
            2'd1: ext_w = sext ? {{16{asm_w[15]}}, asm_w[15:0]}
                               : {16'b0, asm_w[15:0]};
            default: ext_w = asm_w;
        endcase
    end

    always_comb begin
        n_state    = state;
        n_mem_a    = mem_a;
        n_mem_dout = mem_dout;
        n_wr       = wr_reg;
        n_ld_done  = 1'b0;
        n_st_done  = 1'b0;
        n_ld_data  = ld_data;
        n_ld_dest  = ld_dest;
        n_cnt      = cnt;
        n_addr     = addr;
        n_len      = len;
        n_sext     = sext;
        n_src      = src;
        n_ld_buf   = ld_buf;
        n_sdata    = sdata;
        unique case (state)
            IDLE: begin
                if (rb) begin
                    n_state = COOL;
                end else if (st_ok) begin
                    n_state    = STORE;
                    n_mem_a    = st_addr;
                    n_addr     = st_addr;
                    n_mem_dout = st_data[7:0];
                    n_sdata    = st_data;
                    n_wr       = 1'b1;
                    n_cnt      = 2'd0;
                    n_len      = norm_len(st_len);
                end else if (ld_ena) begin
                    n_state = LOAD;
                    n_mem_a = ld_addr;
                    n_addr  = ld_addr;
                    n_cnt   = 2'd0;
                    n_len   = norm_len(ld_len);
                    n_sext  = ld_sext;
                    n_src   = ld_src;
                end
            end
            LOAD: begin
                if (rb) begin
                    n_mem_a = '0;
                    n_state = COOL;
                end else if (cnt < len) begin
                    n_ld_buf = asm_w;
                    n_mem_a  = step_a;
                    n_cnt    = nc;
                end else begin
                    n_ld_buf  = asm_w;
                    n_ld_done = 1'b1;
                    n_ld_data = ext_w;
                    n_ld_dest = src;
                    n_mem_a   = '0;
                    n_state   = COOL;
                end
            end
            STORE: begin
                // Committed stores always finish, rollback or not.
                if (cnt < len) begin
                    n_mem_a    = step_a;
                    n_mem_dout = sdata[{nc, 3'b000} +: 8];
                    n_cnt      = nc;
                end else begin
                    n_wr      = 1'b0;
                    n_mem_a   = '0;
                    n_st_done = 1'b1;
                    n_state   = COOL;
                end
            end
            COOL: n_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_a    <= '0;
            mem_dout <= '0;
            wr_reg   <= 1'b0;
            ld_done  <= 1'b0;
            st_done  <= 1'b0;
            ld_data  <= '0;
            ld_dest  <= '0;
            cnt      <= '0;
            addr     <= '0;
            len      <= '0;
            sext     <= 1'b0;
            src      <= '0;
            ld_buf   <= '0;
            sdata    <= '0;
        end else if (rdy) begin
            state    <= n_state;
            mem_a    <= n_mem_a;
            mem_dout <= n_mem_dout;
            wr_reg   <= n_wr;
            ld_done  <= n_ld_done;
            st_done  <= n_st_done;
            ld_data  <= n_ld_data;
            ld_dest  <= n_ld_dest;
            cnt      <= n_cnt;
            addr     <= n_addr;
            len      <= n_len;
            sext     <= n_sext;
            src      <= n_src;
            ld_buf   <= n_ld_buf;
            sdata    <= n_sdata;
        end
    end

endmodule
